// File: rtl/incubator_pkg.sv
// Shared types and constants for the incubator control blocks.
package incubator_pkg;

    localparam int T_W         = 8;
    localparam int T_RESET_DEF = 25;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        NEXT,
        AVG
    } seq_state_t;

    // Ceiling log2; used for counter and index widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/incubator_tick_gen.sv
// Free-running period timer; emits a single-cycle tick at terminal count while enabled.
module incubator_tick_gen
    import incubator_pkg::*;
#(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int              CNT_W = clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/incubator_sensor_sequencer.sv
// Scans the temperature probes through one shared ADC, averages them and publishes t_avg.
//   state | meaning
//   IDLE  | waiting for a period tick
//   REQ   | adc_req high for probe ch, waiting for ack or timeout
//   NEXT  | adc_req low for one cycle; advance probe or finish
//   AVG   | t_avg freshly loaded, t_valid high
module incubator_sensor_sequencer
    import incubator_pkg::*;
#(
    parameter int NUM_SENSORS   = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int TIMEOUT       = 64,
    parameter int T_RESET       = T_RESET_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    output logic                          adc_req,
    output logic [clog2(NUM_SENSORS)-1:0] adc_sel,
    input  logic                          adc_ack,
    input  logic [T_W-1:0]                adc_data,
    output logic [T_W-1:0]                t_avg,
    output logic                          t_valid,
    output logic [NUM_SENSORS-1:0]        sensor_fault,
    input  logic                          fault_clr,
    output logic                          overrun
);

    localparam int                SEL_W     = clog2(NUM_SENSORS);
    localparam int                ACC_W     = T_W + SEL_W;
    localparam int                WAIT_W    = clog2(TIMEOUT + 1);
    localparam logic [SEL_W-1:0]  LAST_CH   = SEL_W'(NUM_SENSORS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    seq_state_t              state, state_nxt;
    logic [SEL_W-1:0]        ch, ch_nxt;
    logic [WAIT_W-1:0]       wait_cnt, wait_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic signed [ACC_W-1:0] data_ext, held_ext, avg_full;
    logic [T_W-1:0]          t_avg_nxt;
    logic                    t_valid_nxt;
    logic [NUM_SENSORS-1:0]  fault_set;
    logic                    overrun_set;
    logic                    tick;

    incubator_tick_gen #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    assign adc_sel = ch;

    // A faulted probe contributes the currently published value instead of a sample.
    assign data_ext = {{SEL_W{adc_data[T_W-1]}}, adc_data};
    assign held_ext = {{SEL_W{t_avg[T_W-1]}}, t_avg};
    assign avg_full = acc >>> SEL_W;

    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        wait_nxt    = wait_cnt;
        acc_nxt     = acc;
        t_avg_nxt   = t_avg;
        t_valid_nxt = 1'b0;
        fault_set   = '0;
        adc_req     = 1'b0;
        overrun_set = tick && (state != IDLE);

        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = REQ;
                    ch_nxt    = '0;
                    acc_nxt   = '0;
                    wait_nxt  = '0;
                end
            end
            REQ: begin
                adc_req = 1'b1;
                if (adc_ack) begin
                    acc_nxt   = acc + data_ext;
                    state_nxt = NEXT;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault_set[ch] = 1'b1;
                    acc_nxt       = acc + held_ext;
                    state_nxt     = NEXT;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            NEXT: begin
                // Load t_avg on the way into AVG so it is already new while t_valid is high.
                if (ch == LAST_CH) begin
                    t_avg_nxt   = avg_full[T_W-1:0];
                    t_valid_nxt = 1'b1;
                    state_nxt   = AVG;
                end else begin
                    ch_nxt    = ch + 1'b1;
                    wait_nxt  = '0;
                    state_nxt = REQ;
                end
            end
            AVG: begin
                ch_nxt    = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ch           <= '0;
            wait_cnt     <= '0;
            acc          <= '0;
            t_avg        <= T_W'(T_RESET);
            t_valid      <= 1'b0;
            sensor_fault <= '0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nxt;
            ch           <= ch_nxt;
            wait_cnt     <= wait_nxt;
            acc          <= acc_nxt;
            t_avg        <= t_avg_nxt;
            t_valid      <= t_valid_nxt;
            // New faults or overruns take priority over a clear in the same cycle.
            sensor_fault <= (fault_clr ? '0 : sensor_fault) | fault_set;
            overrun      <= (overrun && !fault_clr) || overrun_set;
        end
    end

endmodule

// File: tb/tb_incubator_sensor_sequencer.sv
// Directed bench for incubator_sensor_sequencer: scan table plus reset, overrun and clear sequences.
module tb_incubator_sensor_sequencer;

    localparam int N       = 4;
    localparam int PERIOD  = 10;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       adc_ack = 1'b0;
    logic [7:0] adc_data = 8'd0;
    logic       fault_clr = 1'b0;
    logic       adc_req;
    logic [1:0] adc_sel;
    logic [7:0] t_avg;
    logic       t_valid;
    logic [3:0] sensor_fault;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // ADC model controls, written only by the stimulus process
    logic [3:0][7:0] dat_m = '0;
    logic [3:0]      dead_m = '0;
    int              ack_dly = 3;
    bit              clr_to_m = 1'b0;
    bit              clr_req = 1'b0;
    int              req_age = 0;

    typedef struct {
        string           name;
        logic [3:0][7:0] data;
        logic [3:0]      dead;
        int              dly;
        bit              clr_to;
        logic [7:0]      exp_avg;
        logic [3:0]      exp_fault;
        int              exp_lat;
    } vec_t;

    vec_t vecs[10];

    incubator_sensor_sequencer #(
        .NUM_SENSORS   (N),
        .SAMPLE_PERIOD (PERIOD),
        .TIMEOUT       (TIMEOUT),
        .T_RESET       (25)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .adc_req      (adc_req),
        .adc_sel      (adc_sel),
        .adc_ack      (adc_ack),
        .adc_data     (adc_data),
        .t_avg        (t_avg),
        .t_valid      (t_valid),
        .sensor_fault (sensor_fault),
        .fault_clr    (fault_clr),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // ADC front-end model: acks ack_dly cycles after req rises, dead probes never ack.
    always @(negedge clk) begin
        bit coincide;
        coincide = 1'b0;
        adc_ack  = 1'b0;
        if (adc_req) begin
            if (!dead_m[adc_sel] && req_age == ack_dly) begin
                adc_ack  = 1'b1;
                adc_data = dat_m[adc_sel];
            end
            if (clr_to_m && dead_m[adc_sel] && req_age == TIMEOUT - 1) coincide = 1'b1;
            req_age++;
        end else begin
            req_age = 0;
        end
        fault_clr = clr_req || coincide;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [3:0][7:0] data,
                                input logic [3:0] dead, input int dly, input bit clr_to,
                                input logic [7:0] exp_avg, input logic [3:0] exp_fault,
                                input int exp_lat);
        vec_t v;
        v.name = name; v.data = data; v.dead = dead; v.dly = dly; v.clr_to = clr_to;
        v.exp_avg = exp_avg; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic wait_req(input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!adc_req && cyc < 50);
        check({name, " start_delay"}, cyc, PERIOD);
    endtask

    task automatic run_row(input vec_t v);
        int cyc;
        dat_m    = v.data;
        dead_m   = v.dead;
        ack_dly  = v.dly;
        clr_to_m = v.clr_to;
        @(negedge clk);
        enable = 1'b1;
        wait_req(v.name, cyc);
        enable = 1'b0;
        cyc = 0;
        while (!t_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({v.name, " latency"}, cyc, v.exp_lat);
        check({v.name, " t_avg"}, t_avg, v.exp_avg);
        check({v.name, " sensor_fault"}, sensor_fault, v.exp_fault);
        check({v.name, " overrun"}, overrun, 0);
        @(negedge clk);
        check({v.name, " t_valid_width"}, t_valid, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int cyc;
        int cnt;

        vecs[0] = mk("nominal",     {8'd40, 8'hFE, 8'd22, 8'd20}, 4'b0000, 3,  1'b0, 8'd20,  4'b0000, 20);
        vecs[1] = mk("rounding",    {8'hFE, 8'hFE, 8'hFE, 8'hFF}, 4'b0000, 3,  1'b0, 8'hFE,  4'b0000, 20);
        vecs[2] = mk("preload30",   {8'd30, 8'd30, 8'd30, 8'd30}, 4'b0000, 1,  1'b0, 8'd30,  4'b0000, 12);
        vecs[3] = mk("timeout2",    {8'd30, 8'd99, 8'd30, 8'd30}, 4'b0100, 3,  1'b0, 8'd30,  4'b0100, 80);
        vecs[4] = mk("ack_at_last", {8'd13, 8'd12, 8'd11, 8'd10}, 4'b0000, 63, 1'b0, 8'd11,  4'b0100, 260);
        vecs[5] = mk("all_dead",    {8'd1,  8'd2,  8'd3,  8'd4},  4'b1111, 3,  1'b0, 8'd11,  4'b1111, 260);
        vecs[6] = mk("max_pos",     {8'd127, 8'd127, 8'd127, 8'd127}, 4'b0000, 0, 1'b0, 8'h7F, 4'b1111, 8);
        vecs[7] = mk("max_neg",     {8'h80, 8'h80, 8'h80, 8'h80}, 4'b0000, 2,  1'b0, 8'h80,  4'b1111, 16);
        vecs[8] = mk("dead3",       {8'd77, 8'd29, 8'd25, 8'd21}, 4'b1000, 3,  1'b0, 8'd25,  4'b1000, 80);
        vecs[9] = mk("clr_set1",    {8'd6,  8'd9,  8'd77, 8'd5},  4'b0010, 3,  1'b1, 8'd11,  4'b0010, 80);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst adc_req", adc_req, 0);
        check("rst adc_sel", adc_sel, 0);
        check("rst t_avg", t_avg, 25);
        check("rst t_valid", t_valid, 0);
        check("rst sensor_fault", sensor_fault, 0);
        check("rst overrun", overrun, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_row(vecs[i]);

        // Reset in the middle of a REQ with faults and a non-default t_avg present
        dead_m = 4'b1111;
        clr_to_m = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_req("midreset", cyc);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset adc_req_before", adc_req, 1);
        #2 rst = 1'b0;
        #1;
        check("midreset adc_req", adc_req, 0);
        check("midreset t_avg", t_avg, 25);
        check("midreset sensor_fault", sensor_fault, 0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (t_valid || adc_req) cnt++;
        end
        check("midreset no_activity", cnt, 0);

        for (int i = 8; i < 10; i++) run_row(vecs[i]);

        // Overrun: enable kept high so a tick lands mid-scan
        dat_m = {8'd8, 8'd8, 8'd8, 8'd8};
        dead_m = 4'b0000;
        ack_dly = 3;
        clr_to_m = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_req("overrun", cyc);
        repeat (15) @(negedge clk);
        check("overrun set", overrun, 1);
        enable = 1'b0;
        cyc = 0;
        while (!t_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("overrun publish", t_valid, 1);
        check("overrun t_avg", t_avg, 8);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (adc_req) cnt++;
        end
        check("overrun no_queue", cnt, 0);
        check("overrun sticky", overrun, 1);
        check("overrun fault_kept", sensor_fault, 4'b0010);

        // Plain clear
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        @(negedge clk);
        check("clear sensor_fault", sensor_fault, 0);
        check("clear overrun", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
